// File: rtl/frame_buffer_arbiter_if.sv
// -----------------------------------------------------------------------------
// frame_buffer_arbiter_if
// Groups the host write handshake, the display frame-boundary strobe and the
// status/statistics outputs of frame_buffer_arbiter.
//
// Handshake semantics:
//   wr_req is a level held by the host until it sees wr_grant=1. wr_grant
//   stays high (with wr_sel naming the buffer) until the host pulses wr_done
//   for one cycle, after which wr_grant drops for at least one cycle before
//   any new grant. A wr_done pulse while wr_grant=0 is a protocol error.
//   rd_frame_start is a one-cycle strobe; rd_sel/rd_valid follow one cycle
//   later.
//
// Modports:
//   master : host/display side (drives requests, reads status)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface frame_buffer_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             wr_req;
  logic             wr_done;
  logic             rd_frame_start;
  logic             clr_stats;
  logic             wr_grant;
  logic             wr_sel;
  logic             rd_valid;
  logic             rd_sel;
  logic [1:0]       buf_full;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] repeat_cnt;
  logic             err_sticky;
  // {state of buffer 1, state of buffer 0}, 2 bits each
  logic [3:0]       dbg_buf_state;

  modport master (
    output wr_req, wr_done, rd_frame_start, clr_stats,
    input  wr_grant, wr_sel, rd_valid, rd_sel, buf_full,
           frame_cnt, repeat_cnt, err_sticky, dbg_buf_state
  );

  modport slave (
    input  wr_req, wr_done, rd_frame_start, clr_stats,
    output wr_grant, wr_sel, rd_valid, rd_sel, buf_full,
           frame_cnt, repeat_cnt, err_sticky, dbg_buf_state
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// frame_buffer_arbiter
// Double-buffer ownership arbiter between a host writer and a display reader.
// Each buffer cycles EMPTY -> WRITING -> FULL -> READING -> EMPTY. The display
// swaps to the oldest FULL buffer at each frame start, or repeats the current
// one when nothing new is ready.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : frame_buffer_arbiter_if.slave (requests in, grant/status out)
//           dbg_buf_state exposes the per-buffer state registers.
// -----------------------------------------------------------------------------
module frame_buffer_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  frame_buffer_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_WRITING = 2'd1,
    ST_FULL    = 2'd2,
    ST_READING = 2'd3
  } buf_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  buf_state_t       r_st [2];
  logic             r_age;
  logic             r_wr_grant;
  logic             r_wr_sel;
  logic             r_rd_valid;
  logic             r_rd_sel;
  logic [1:0]       r_buf_full;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_repeat_cnt;
  logic             r_err;

  buf_state_t       w_st [2];
  logic             w_age;
  logic             w_wr_grant;
  logic             w_wr_sel;
  logic             w_rd_valid;
  logic             w_rd_sel;
  logic [1:0]       w_buf_full;
  logic [CNT_W-1:0] w_frame_cnt;
  logic [CNT_W-1:0] w_repeat_cnt;
  logic             w_err;
  logic             w_complete;
  logic             w_swap;
  logic             w_swap_idx;
  logic             w_gnt;
  logic             w_gnt_idx;

  always_comb begin
    w_st[0]      = r_st[0];
    w_st[1]      = r_st[1];
    w_age        = r_age;
    w_wr_grant   = r_wr_grant;
    w_wr_sel     = r_wr_sel;
    w_rd_valid   = r_rd_valid;
    w_rd_sel     = r_rd_sel;
    w_frame_cnt  = r_frame_cnt;
    w_repeat_cnt = r_repeat_cnt;
    w_err        = r_err;
    w_complete   = 1'b0;
    w_swap       = 1'b0;
    w_swap_idx   = r_age;
    w_gnt        = 1'b0;
    w_gnt_idx    = 1'b0;

    // Write completion
    if (bus.wr_done) begin
      if (r_wr_grant) begin
        w_complete      = 1'b1;
        w_st[r_wr_sel]  = ST_FULL;
        w_wr_grant      = 1'b0;
      end else begin
        w_err = 1'b1;
      end
    end

    // Frame swap looks only at the registered states, so a buffer completing
    // in this same cycle is not yet eligible.
    if (bus.rd_frame_start) begin
      if (r_st[0] == ST_FULL && r_st[1] == ST_FULL) begin
        w_swap     = 1'b1;
        w_swap_idx = r_age;
      end else if (r_st[0] == ST_FULL) begin
        w_swap     = 1'b1;
        w_swap_idx = 1'b0;
      end else if (r_st[1] == ST_FULL) begin
        w_swap     = 1'b1;
        w_swap_idx = 1'b1;
      end

      if (w_swap) begin
        if (r_st[0] == ST_READING) w_st[0] = ST_EMPTY;
        if (r_st[1] == ST_READING) w_st[1] = ST_EMPTY;
        w_st[w_swap_idx] = ST_READING;
        w_rd_sel         = w_swap_idx;
        w_rd_valid       = 1'b1;
        if (r_frame_cnt != '1) w_frame_cnt = r_frame_cnt + CNT_ONE;
      end else begin
        if (r_repeat_cnt != '1) w_repeat_cnt = r_repeat_cnt + CNT_ONE;
      end
    end

    // The newly FULL buffer is the oldest unless the other one is still FULL
    // after this cycle's swap.
    if (w_complete) begin
      w_age = (w_st[~r_wr_sel] == ST_FULL) ? ~r_wr_sel : r_wr_sel;
    end

    // Grant is evaluated on post-swap states; r_wr_grant being high in a
    // wr_done cycle guarantees the mandatory idle cycle before a new grant.
    if (bus.wr_req && !r_wr_grant &&
        w_st[0] != ST_WRITING && w_st[1] != ST_WRITING) begin
      if (w_rd_valid && w_st[~w_rd_sel] == ST_EMPTY) begin
        w_gnt     = 1'b1;
        w_gnt_idx = ~w_rd_sel;
      end else if (w_st[0] == ST_EMPTY) begin
        w_gnt     = 1'b1;
        w_gnt_idx = 1'b0;
      end else if (w_st[1] == ST_EMPTY) begin
        w_gnt     = 1'b1;
        w_gnt_idx = 1'b1;
      end
      if (w_gnt) begin
        w_st[w_gnt_idx] = ST_WRITING;
        w_wr_grant      = 1'b1;
        w_wr_sel        = w_gnt_idx;
      end
    end

    if (bus.clr_stats) begin
      w_frame_cnt  = '0;
      w_repeat_cnt = '0;
      w_err        = 1'b0;
    end

    w_buf_full[0] = (w_st[0] == ST_FULL) || (w_st[0] == ST_READING);
    w_buf_full[1] = (w_st[1] == ST_FULL) || (w_st[1] == ST_READING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st[0]      <= ST_EMPTY;
      r_st[1]      <= ST_EMPTY;
      r_age        <= 1'b0;
      r_wr_grant   <= 1'b0;
      r_wr_sel     <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_buf_full   <= 2'b00;
      r_frame_cnt  <= '0;
      r_repeat_cnt <= '0;
      r_err        <= 1'b0;
    end else begin
      r_st[0]      <= w_st[0];
      r_st[1]      <= w_st[1];
      r_age        <= w_age;
      r_wr_grant   <= w_wr_grant;
      r_wr_sel     <= w_wr_sel;
      r_rd_valid   <= w_rd_valid;
      r_rd_sel     <= w_rd_sel;
      r_buf_full   <= w_buf_full;
      r_frame_cnt  <= w_frame_cnt;
      r_repeat_cnt <= w_repeat_cnt;
      r_err        <= w_err;
    end
  end

  assign bus.wr_grant      = r_wr_grant;
  assign bus.wr_sel        = r_wr_sel;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.rd_sel        = r_rd_sel;
  assign bus.buf_full      = r_buf_full;
  assign bus.frame_cnt     = r_frame_cnt;
  assign bus.repeat_cnt    = r_repeat_cnt;
  assign bus.err_sticky    = r_err;
  assign bus.dbg_buf_state = {r_st[1], r_st[0]};

endmodule
